// File: rtl/control_mux_driver.sv
// Initiator for the Bandera / Band_Listo stepping handshake towards ControlMux.
// Issues periodic step pulses, captures the accumulator on done, and flags a sticky timeout.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; Band_Listo ignored
// PULSE   | Bandera high for one cycle; step_count already advanced
// GAP     | Bandera low, counting down STEP_GAP cycles towards next pulse
// CAPTURE | result updated from acum_in, result_valid high for one cycle
// ERR     | step budget exhausted without Band_Listo; error held high
module control_mux_driver #(
  parameter int DATA_W    = 16,
  parameter int STEP_GAP  = 4,
  parameter int MAX_STEPS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              Band_Listo,
  input  logic [DATA_W-1:0] acum_in,
  output logic              Bandera,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              error,
  output logic [3:0]        step_count
);

  localparam int GAP_W = $clog2(STEP_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(STEP_GAP - 1);
  localparam logic [3:0] MAX_STEPS_C = 4'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PULSE   = 3'd1,
    S_GAP     = 3'd2,
    S_CAPTURE = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [3:0]        step_count_q, step_count_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              bandera_q, bandera_d;
  logic              busy_q, busy_d;
  logic              result_valid_q, result_valid_d;
  logic              error_q, error_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      gap_cnt_q      <= '0;
      step_count_q   <= '0;
      result_q       <= '0;
      bandera_q      <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      gap_cnt_q      <= gap_cnt_d;
      step_count_q   <= step_count_d;
      result_q       <= result_d;
      bandera_q      <= bandera_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
    end
  end

  // Next state, gap timer, step counter and capture.
  // Entering PULSE from IDLE/ERR clears and advances the count in one go, so it reads 1.
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    step_count_d = step_count_q;
    result_d     = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_PULSE;
          step_count_d = 4'd1;
        end
      end
      S_PULSE: begin
        if (Band_Listo) begin
          state_d  = S_CAPTURE;
          result_d = acum_in;
        end else begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (Band_Listo) begin
          state_d  = S_CAPTURE;
          result_d = acum_in;
        end else if (gap_cnt_q == '0) begin
          if (step_count_q == MAX_STEPS_C) begin
            state_d = S_ERR;
          end else begin
            state_d      = S_PULSE;
            step_count_d = step_count_q + 4'd1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (start) begin
          state_d      = S_PULSE;
          step_count_d = 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops
  always_comb begin
    bandera_d      = 1'b0;
    busy_d         = 1'b0;
    result_valid_d = 1'b0;
    error_d        = 1'b0;
    case (state_d)
      S_PULSE: begin
        bandera_d = 1'b1;
        busy_d    = 1'b1;
      end
      S_GAP: begin
        busy_d = 1'b1;
      end
      S_CAPTURE: begin
        busy_d         = 1'b1;
        result_valid_d = 1'b1;
      end
      S_ERR: begin
        error_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign Bandera      = bandera_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign error        = error_q;
  assign step_count   = step_count_q;

endmodule

// File: tb/tb_control_mux_driver.sv
// Bench for control_mux_driver: directed scenarios then random traffic,
// checked against a time-index model of the stepping sequence.
module tb_control_mux_driver;

  localparam int DATA_W    = 16;
  localparam int STEP_GAP  = 4;
  localparam int MAX_STEPS = 8;
  localparam int PERIOD    = STEP_GAP + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              Band_Listo;
  logic [DATA_W-1:0] acum_in;
  logic              Bandera;
  logic              busy;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              error;
  logic [3:0]        step_count;

  control_mux_driver #(
    .DATA_W(DATA_W), .STEP_GAP(STEP_GAP), .MAX_STEPS(MAX_STEPS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .Band_Listo(Band_Listo),
    .acum_in(acum_in), .Bandera(Bandera), .busy(busy), .result(result),
    .result_valid(result_valid), .error(error), .step_count(step_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_pulse = 0;
  int n_valid = 0;

  // Model: m_t is cycles since the sequence began (1 = first pulse), 0 when not stepping
  int              m_t = 0;
  bit              m_cap = 1'b0;
  bit              m_err = 1'b0;
  logic [DATA_W-1:0] m_result = '0;
  int              m_steps = 0;

  function automatic void model_edge(bit r, bit s, bit bl, logic [DATA_W-1:0] a);
    if (!r) begin
      m_t = 0; m_cap = 1'b0; m_err = 1'b0; m_result = '0; m_steps = 0;
    end else if (m_cap) begin
      m_cap = 1'b0;
    end else if (m_t > 0) begin
      if (bl) begin
        m_result = a; m_cap = 1'b1; m_t = 0;
      end else if (m_t + 1 > MAX_STEPS * PERIOD) begin
        m_err = 1'b1; m_t = 0;
      end else begin
        m_t = m_t + 1;
        m_steps = (m_t - 1) / PERIOD + 1;
      end
    end else if (s) begin
      m_t = 1; m_err = 1'b0; m_steps = 1;
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(bit r, bit s, bit bl, logic [DATA_W-1:0] a);
    reset = r; start = s; Band_Listo = bl; acum_in = a;
    @(posedge clk);
    model_edge(r, s, bl, a);
    #1;
    if (Bandera === 1'b1) n_pulse++;
    if (result_valid === 1'b1) n_valid++;
    chk("bandera", Bandera, (m_t > 0 && ((m_t - 1) % PERIOD) == 0));
    chk("busy", busy, (m_t > 0 || m_cap));
    chk("result_valid", result_valid, m_cap);
    chk("error", error, m_err);
    chk("step_count", step_count, m_steps);
    chk("result", result, m_result);
  endtask

  task automatic run_to(int target);
    for (int i = 0; i < 60 && m_t != target; i++) step(1'b1, 1'b0, 1'b0, 16'($urandom));
    chk("reach_step_time", m_t, target);
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; Band_Listo = 1'b0; acum_in = '0;

    // Reset dominates start
    n_pulse = 0;
    repeat (3) step(1'b0, 1'b1, 1'b0, 16'h5555);
    chk("rst_no_pulse", n_pulse, 0);

    // Start then let the budget run out
    n_pulse = 0;
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("first_pulse", Bandera, 1'b1);
    for (int i = 0; i < 60 && !m_err; i++) step(1'b1, 1'b0, 1'b0, 16'($urandom));
    chk("timeout_pulses", n_pulse, MAX_STEPS);
    chk("timeout_error", error, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b0, 16'($urandom));
    chk("err_sticky", error, 1'b1);
    chk("err_result_kept", result, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("err_clear", error, 1'b0);
    chk("err_restart_pulse", Bandera, 1'b1);

    // Capture in 2nd gap cycle after 3rd pulse; start held through the capture cycle
    run_to(2 * PERIOD + 3);
    step(1'b1, 1'b0, 1'b1, 16'h1A2B);
    chk("cap_result", result, 16'h1A2B);
    chk("cap_valid", result_valid, 1'b1);
    chk("cap_steps", step_count, 4'd3);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("cap_idle_busy", busy, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("turnaround_pulse", Bandera, 1'b1);

    // Done in the last gap cycle of the final step beats the timeout
    run_to(MAX_STEPS * PERIOD);
    step(1'b1, 1'b0, 1'b1, 16'hBEEF);
    chk("late_cap_result", result, 16'hBEEF);
    chk("late_cap_no_err", error, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0);

    // Done sampled during a pulse
    step(1'b1, 1'b1, 1'b0, 16'h0);
    run_to(PERIOD + 1);
    step(1'b1, 1'b0, 1'b1, 16'h0F0F);
    chk("pulse_cap_result", result, 16'h0F0F);
    n_pulse = 0;
    repeat (8) step(1'b1, 1'b0, 1'b0, 16'($urandom));
    chk("pulse_cap_no_more", n_pulse, 0);

    // Start ignored while busy; long Band_Listo gives one capture
    step(1'b1, 1'b1, 1'b0, 16'h0);
    run_to(3);
    repeat (2) step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("gap_start_ignored", step_count, 4'd1);
    n_valid = 0;
    repeat (5) step(1'b1, 1'b0, 1'b1, 16'($urandom));
    chk("single_valid", n_valid, 1);
    step(1'b1, 1'b0, 1'b0, 16'h0);

    // Reset in the middle of a sequence
    step(1'b1, 1'b1, 1'b0, 16'h0);
    run_to(PERIOD + 2);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("midrst_steps", step_count, 4'd0);
    chk("midrst_result", result, 16'h0);
    chk("midrst_busy", busy, 1'b0);
    n_pulse = 0;
    repeat (12) step(1'b1, 1'b0, 1'b0, 16'($urandom));
    chk("midrst_quiet", n_pulse, 0);

    // Random traffic
    for (int i = 0; i < 800; i++)
      step(($urandom % 64) != 0, ($urandom % 4) == 0, ($urandom % 8) == 0, 16'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
